// File: rtl/e_calc_pkg.sv
// Shared types and constants for the exp(1/D) series calculator.
package e_calc_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int ITER_W     = 16;

    typedef logic [WORD_W_DEF-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DIV,
        ADD,
        OUT
    } state_t;

endpackage

// File: rtl/e_calc_series_if.sv
// Command, status and result-stream bundle of the e_calc_series calculator.
interface e_calc_series_if #(
    parameter int WORDS  = 32,
    parameter int WORD_W = e_calc_pkg::WORD_W_DEF
);
    import e_calc_pkg::*;

    logic                    start;
    logic [WORD_W-1:0]       div_d;
    logic                    busy;
    logic                    done;
    logic                    truncated;
    logic [ITER_W-1:0]       iter_count;
    logic [WORDS*WORD_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WORD_W-1:0]       out_word;
    logic                    out_last;

    modport slave (
        input  start, div_d, out_ready,
        output busy, done, truncated, iter_count, out_data,
        output out_valid, out_word, out_last
    );

    modport master (
        output start, div_d, out_ready,
        input  busy, done, truncated, iter_count, out_data,
        input  out_valid, out_word, out_last
    );

endinterface

// File: rtl/e_calc_divstep.sv
// One long-division step: {rem, word} / q -> quotient word and new remainder.
module e_calc_divstep #(
    parameter int WORD_W = 16
) (
    input  logic [2*WORD_W-1:0] i_rem,
    input  logic [WORD_W-1:0]   i_word,
    input  logic [2*WORD_W-1:0] i_q,
    output logic [WORD_W-1:0]   o_quo,
    output logic [2*WORD_W-1:0] o_rem
);
    localparam int DW = 3 * WORD_W;

    logic [DW-1:0]         w_dividend;
    logic [DW-1:0]         w_divisor;
    logic [DW-1:0]         w_quo_full;
    logic [DW-1:0]         w_rem_full;
    logic [2*WORD_W-1:0]   w_unused_quo_hi;
    logic [WORD_W-1:0]     w_unused_rem_hi;

    assign w_dividend = {i_rem, i_word};
    assign w_divisor  = {{WORD_W{1'b0}}, i_q};
    assign w_quo_full = w_dividend / w_divisor;
    assign w_rem_full = w_dividend % w_divisor;

    // i_rem < i_q keeps the quotient inside one word; the upper bits are always zero.
    assign {w_unused_quo_hi, o_quo} = w_quo_full;
    assign {w_unused_rem_hi, o_rem} = w_rem_full;

endmodule

// File: rtl/e_calc_series.sv
// Word-serial fixed-point evaluation of exp(1/D) = sum 1/(D^k k!).
// Define E_CALC_GUARD_EN to carry one extra guard word below the LSW.
module e_calc_series
    import e_calc_pkg::*;
#(
    parameter int WORDS  = 32,
    parameter int WORD_W = WORD_W_DEF,
    parameter int MAX_K  = 4096
) (
    input  logic           clk,
    input  logic           rst_n,
    e_calc_series_if.slave bus
);
`ifdef E_CALC_GUARD_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    localparam int AW     = WORDS + G;
    localparam int IDX_W  = (AW > 1) ? $clog2(AW) : 1;
    localparam int OIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int K_W    = $clog2(MAX_K + 1);
    localparam int QW     = 2 * WORD_W;

    state_t                  r_state, w_state_nxt;
    logic [WORD_W-1:0]       r_term     [AW];
    logic [WORD_W-1:0]       r_sum      [AW];
    logic [WORD_W-1:0]       w_sum_view [AW];
    logic [IDX_W-1:0]        r_idx, w_ridx;
    logic [OIDX_W-1:0]       r_oidx, w_oidx_dec;
    logic [QW-1:0]           r_rem, w_rem, w_q;
    logic [WORD_W-1:0]       w_quo, r_d;
    logic                    r_carry, r_nz, w_nz_all;
    logic [K_W-1:0]          r_k;
    logic [ITER_W-1:0]       r_iter;
    logic                    r_trunc, r_done;
    logic [WORDS*WORD_W-1:0] r_out_data, w_out_pack;
    logic [WORD_W-1:0]       r_out_word;
    logic                    r_out_valid, r_out_last;
    logic [WORD_W:0]         w_add_full;
    logic                    w_div_last, w_add_last, w_k_max, w_enter_out, w_hs;

    assign w_q = QW'(r_k) * QW'(r_d);

    e_calc_divstep #(.WORD_W(WORD_W)) u_divstep (
        .i_rem  (r_rem),
        .i_word (r_term[r_idx]),
        .i_q    (w_q),
        .o_quo  (w_quo),
        .o_rem  (w_rem)
    );

    assign w_nz_all    = r_nz | (|w_quo);
    assign w_add_full  = {1'b0, r_sum[r_idx]} + {1'b0, r_term[r_idx]} + {{WORD_W{1'b0}}, r_carry};
    assign w_div_last  = (r_idx == '0);
    assign w_add_last  = (r_idx == IDX_W'(AW - 1));
    assign w_k_max     = (r_k == K_W'(MAX_K));
    assign w_hs        = r_out_valid & bus.out_ready;
    assign w_oidx_dec  = r_oidx - OIDX_W'(1);
    assign w_ridx      = IDX_W'(w_oidx_dec) + IDX_W'(G);
    assign w_enter_out = (r_state != OUT) && (w_state_nxt == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (bus.start) w_state_nxt = INIT;
            INIT: w_state_nxt = DIV;
            DIV:  if (w_div_last) w_state_nxt = w_nz_all ? ADD : OUT;
            ADD:  if (w_add_last) w_state_nxt = w_k_max ? OUT : DIV;
            OUT:  if (w_hs && r_out_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The MSW is still being written on the last ADD cycle, so OUT loads from this view.
    always_comb begin
        for (int i = 0; i < AW; i++) w_sum_view[i] = r_sum[i];
        if (r_state == ADD) w_sum_view[r_idx] = w_add_full[WORD_W-1:0];
    end

    always_comb begin
        w_out_pack = '0;
        for (int j = 0; j < WORDS; j++) w_out_pack[j*WORD_W +: WORD_W] = w_sum_view[j + G];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < AW; i++) begin
                r_term[i] <= '0;
                r_sum[i]  <= '0;
            end
            r_idx       <= '0;
            r_oidx      <= '0;
            r_rem       <= '0;
            r_carry     <= 1'b0;
            r_nz        <= 1'b0;
            r_k         <= K_W'(1);
            r_d         <= WORD_W'(1);
            r_iter      <= '0;
            r_trunc     <= 1'b0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_done <= w_enter_out;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_d     <= (bus.div_d == '0) ? WORD_W'(1) : bus.div_d;
                        r_trunc <= 1'b0;
                    end
                end
                INIT: begin
                    for (int i = 0; i < AW; i++) begin
                        r_term[i] <= (i == AW - 1) ? WORD_W'(1) : '0;
                        r_sum[i]  <= (i == AW - 1) ? WORD_W'(1) : '0;
                    end
                    r_k    <= K_W'(1);
                    r_iter <= '0;
                    r_nz   <= 1'b0;
                    r_rem  <= '0;
                    r_idx  <= IDX_W'(AW - 1);
                end
                DIV: begin
                    r_term[r_idx] <= w_quo;
                    r_rem         <= w_rem;
                    r_nz          <= w_nz_all;
                    if (w_div_last) r_carry <= 1'b0;
                    else            r_idx   <= r_idx - IDX_W'(1);
                end
                ADD: begin
                    r_sum[r_idx] <= w_add_full[WORD_W-1:0];
                    r_carry      <= w_add_full[WORD_W];
                    if (w_add_last) begin
                        r_iter <= r_iter + ITER_W'(1);
                        if (w_k_max) begin
                            r_trunc <= 1'b1;
                        end else begin
                            r_k   <= r_k + K_W'(1);
                            r_idx <= IDX_W'(AW - 1);
                            r_rem <= '0;
                            r_nz  <= 1'b0;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                OUT: begin
                    if (w_hs) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_oidx     <= w_oidx_dec;
                            r_out_word <= r_sum[w_ridx];
                            r_out_last <= (w_oidx_dec == '0);
                        end
                    end
                end
                default: ;
            endcase
            if (w_enter_out) begin
                r_out_data  <= w_out_pack;
                r_out_word  <= w_sum_view[AW-1];
                r_out_valid <= 1'b1;
                r_out_last  <= (WORDS == 1);
                r_oidx      <= OIDX_W'(WORDS - 1);
            end
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.truncated  = r_trunc;
    assign bus.iter_count = r_iter;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_word   = r_out_word;
    assign bus.out_last   = r_out_last;

endmodule

// File: tb/tb_e_calc_series.sv
// Scoreboard bench for e_calc_series: a 4-word instance and a 2-word instance with MAX_K=3.
module tb_e_calc_series;
    import e_calc_pkg::*;

    typedef struct {
        string name;
        word_t lo;
        word_t hi;
        logic  last;
    } wexp_t;

    typedef struct {
        int   lo;
        int   hi;
        logic trunc;
    } sexp_t;

`ifdef E_CALC_GUARD_EN
    localparam word_t E_W0_LO = 16'h8AE0, E_W0_HI = 16'h8AED;
    localparam int    E_IT_LO = 16, E_IT_HI = 20;
    localparam word_t H_W0_LO = 16'hE055, H_W0_HI = 16'hE069;
    localparam int    H_IT_LO = 13, H_IT_HI = 20;
`else
    localparam word_t E_W0_LO = 16'h8AE5, E_W0_HI = 16'h8AE5;
    localparam int    E_IT_LO = 16, E_IT_HI = 16;
    localparam word_t H_W0_LO = 16'hE065, H_W0_HI = 16'hE065;
    localparam int    H_IT_LO = 13, H_IT_HI = 13;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    wexp_t q4[$];
    sexp_t qs4[$];
    wexp_t q2[$];
    sexp_t qs2[$];
    wexp_t e4, e2;
    sexp_t s4, s2;

    e_calc_series_if #(.WORDS(4), .WORD_W(16)) bus4 ();
    e_calc_series_if #(.WORDS(2), .WORD_W(16)) bus2 ();

    e_calc_series #(.WORDS(4), .WORD_W(16), .MAX_K(4096)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    e_calc_series #(.WORDS(2), .WORD_W(16), .MAX_K(3)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input longint unsigned act,
                                input longint unsigned lo, input longint unsigned hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h..0x%0h", nm, act, lo, hi);
        end
    endfunction

    // Monitors sample just after the falling edge, once the bench has settled its inputs.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus4.out_valid && bus4.out_ready) begin
                if (q4.size() == 0) chk("stream4_extra", bus4.out_valid, 0, 0);
                else begin
                    e4 = q4.pop_front();
                    chk({"stream4_", e4.name}, bus4.out_word, e4.lo, e4.hi);
                    chk({"last4_", e4.name}, bus4.out_last, e4.last, e4.last);
                end
            end else if (bus4.out_valid && q4.size() != 0) begin
                chk({"hold4_", q4[0].name}, bus4.out_word, q4[0].lo, q4[0].hi);
            end
            if (bus4.done) begin
                if (qs4.size() == 0) chk("done4_extra", bus4.done, 0, 0);
                else begin
                    s4 = qs4.pop_front();
                    chk("iter4", bus4.iter_count, s4.lo, s4.hi);
                    chk("trunc4", bus4.truncated, s4.trunc, s4.trunc);
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (bus2.out_valid && bus2.out_ready) begin
                if (q2.size() == 0) chk("stream2_extra", bus2.out_valid, 0, 0);
                else begin
                    e2 = q2.pop_front();
                    chk({"stream2_", e2.name}, bus2.out_word, e2.lo, e2.hi);
                    chk({"last2_", e2.name}, bus2.out_last, e2.last, e2.last);
                end
            end
            if (bus2.done) begin
                if (qs2.size() == 0) chk("done2_extra", bus2.done, 0, 0);
                else begin
                    s2 = qs2.pop_front();
                    chk("iter2", bus2.iter_count, s2.lo, s2.hi);
                    chk("trunc2", bus2.truncated, s2.trunc, s2.trunc);
                end
            end
        end
    end

    task automatic run4(input word_t d, input word_t w3, input word_t w2, input word_t w1,
                        input word_t w0lo, input word_t w0hi, input int it_lo, input int it_hi,
                        input bit poke_div, input bit stall);
        bit seen;
        q4.push_back('{"w3", w3, w3, 1'b0});
        q4.push_back('{"w2", w2, w2, 1'b0});
        q4.push_back('{"w1", w1, w1, 1'b0});
        q4.push_back('{"w0", w0lo, w0hi, 1'b1});
        qs4.push_back('{it_lo, it_hi, 1'b0});
        bus4.out_ready = stall ? 1'b0 : 1'b1;
        @(negedge clk);
        bus4.div_d = d;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.div_d = 16'h0007;
        chk("busy_after_start", bus4.busy, 1, 1);
        if (poke_div) begin
            repeat (2) @(negedge clk);
            bus4.start = 1'b1;
            bus4.div_d = 16'h0005;
            @(negedge clk);
            bus4.start = 1'b0;
            chk("busy_div_poke", bus4.busy, 1, 1);
        end
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (bus4.done) seen = 1'b1;
        end
        chk("done_seen", seen, 1, 1);
        if (seen) begin
            chk("out_data_hi", bus4.out_data[63:16], {w3, w2, w1}, {w3, w2, w1});
            chk("out_data_lo", bus4.out_data[15:0], w0lo, w0hi);
            if (stall) begin
                bus4.out_ready = 1'b1;
                @(negedge clk);
                chk("done_pulse_width", bus4.done, 0, 0);
                bus4.out_ready = 1'b0;
                @(negedge clk);
                chk("stall_valid_a", bus4.out_valid, 1, 1);
                bus4.start = 1'b1;
                bus4.div_d = 16'h0003;
                @(negedge clk);
                bus4.start = 1'b0;
                chk("stall_valid_b", bus4.out_valid, 1, 1);
                chk("busy_stall", bus4.busy, 1, 1);
                bus4.out_ready = 1'b1;
            end else begin
                @(negedge clk);
                chk("done_pulse_width", bus4.done, 0, 0);
            end
            for (int c = 0; c < 50 && bus4.busy; c++) @(negedge clk);
            chk("busy_cleared", bus4.busy, 0, 0);
            chk("truncated_held", bus4.truncated, 0, 0);
        end
        chk("q4_drained", q4.size(), 0, 0);
        chk("qs4_drained", qs4.size(), 0, 0);
        q4.delete();
        qs4.delete();
        bus4.out_ready = 1'b1;
    endtask

    initial begin
        bit seen2;
        rst_n          = 1'b0;
        bus4.start     = 1'b0;
        bus4.div_d     = '0;
        bus4.out_ready = 1'b1;
        bus2.start     = 1'b0;
        bus2.div_d     = '0;
        bus2.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy4", bus4.busy, 0, 0);
        chk("rst_done4", bus4.done, 0, 0);
        chk("rst_valid4", bus4.out_valid, 0, 0);
        chk("rst_last4", bus4.out_last, 0, 0);
        chk("rst_word4", bus4.out_word, 0, 0);
        chk("rst_data4", bus4.out_data, 0, 0);
        chk("rst_iter4", bus4.iter_count, 0, 0);
        chk("rst_trunc4", bus4.truncated, 0, 0);
        chk("rst_busy2", bus2.busy, 0, 0);
        chk("rst_data2", bus2.out_data, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run4(16'd1, 16'h0002, 16'hB7E1, 16'h5162, E_W0_LO, E_W0_HI, E_IT_LO, E_IT_HI, 1'b0, 1'b0);
        run4(16'd2, 16'h0001, 16'hA612, 16'h98E1, H_W0_LO, H_W0_HI, H_IT_LO, H_IT_HI, 1'b1, 1'b0);
        run4(16'd0, 16'h0002, 16'hB7E1, 16'h5162, E_W0_LO, E_W0_HI, E_IT_LO, E_IT_HI, 1'b0, 1'b0);
        run4(16'd1, 16'h0002, 16'hB7E1, 16'h5162, E_W0_LO, E_W0_HI, E_IT_LO, E_IT_HI, 1'b0, 1'b1);

        // MAX_K=3 cap: 1 + 1 + 1/2 + 1/6 truncated to 2+16 bits.
        q2.push_back('{"w1", 16'h0002, 16'h0002, 1'b0});
        q2.push_back('{"w0", 16'hAAAA, 16'hAAAA, 1'b1});
        qs2.push_back('{3, 3, 1'b1});
        @(negedge clk);
        bus2.div_d = 16'd1;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        seen2 = 1'b0;
        for (int c = 0; c < 500 && !seen2; c++) begin
            @(negedge clk);
            if (bus2.done) seen2 = 1'b1;
        end
        chk("done2_seen", seen2, 1, 1);
        chk("out_data2", bus2.out_data, 32'h0002AAAA, 32'h0002AAAA);
        for (int c = 0; c < 50 && bus2.busy; c++) @(negedge clk);
        chk("busy2_cleared", bus2.busy, 0, 0);
        chk("truncated2_held", bus2.truncated, 1, 1);
        chk("iter2_held", bus2.iter_count, 3, 3);
        chk("q2_drained", q2.size(), 0, 0);
        q2.delete();
        qs2.delete();

        // Abort in the first ADD pass: INIT, four DIV cycles, then two ADD cycles.
        @(negedge clk);
        bus4.div_d = 16'd1;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus4.busy, 0, 0);
        chk("abort_done", bus4.done, 0, 0);
        chk("abort_valid", bus4.out_valid, 0, 0);
        chk("abort_data", bus4.out_data, 0, 0);
        chk("abort_iter", bus4.iter_count, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", bus4.done, 0, 0);
        chk("abort_idle", bus4.busy, 0, 0);
        run4(16'd1, 16'h0002, 16'hB7E1, 16'h5162, E_W0_LO, E_W0_HI, E_IT_LO, E_IT_HI, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, want completion before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/e_calc_series.md
Name: e_calc_series

Overview:
- Multi-precision fixed-point calculator for exp(1/D), where D is a runtime divisor.
- D = 1 yields Euler's number e.
- Evaluates the Taylor series sum 1/(D^k k!) with word-serial arithmetic on two on-chip word arrays, term and sum.
- Parametrised successor of the squaring-based e calculator: runtime divisor, iteration cap, early termination, streamed valid/ready result output alongside the flat result bus.

Parameters:
- WORDS, 32, result length in WORD_W-bit words; word WORDS-1 is the integer part, the rest are fraction (MSW first).
- WORD_W, 16, word width in bits.
- MAX_K, 4096, series iteration cap.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle start request; ignored unless IDLE
- div_d  input  WORD_W  divisor D, sampled on accepted start
- busy  output  1  high from accepted start until final output word handshaken
- done  output  1  one-cycle pulse when computation finishes (entering OUT)
- truncated  output  1  series stopped by MAX_K, not by a zero term; valid with done, held until next start
- iter_count  output  16  number of terms added, held until next start
- out_data  output  WORD_W*WORDS  final sum, flat, updated at done
- out_valid  output  1  stream word valid
- out_ready  input  1  stream back-pressure
- out_word  output  WORD_W  stream word, MSW first
- out_last  output  1  marks word 0

Behaviour:
- Reset: all outputs 0, FSM IDLE, arrays cleared. Reset mid-operation aborts immediately; no done is produced.
- Accepted start (IDLE & start): latch D; D == 0 is treated as 1. Set busy next cycle.
- FSM states: IDLE -> INIT -> DIV -> ADD -> (DIV | OUT) -> IDLE.
- INIT (1 cycle):
  - term = sum = 1.0 (word WORDS-1 = 1, others 0).
  - k = 1, iter_count = 0, nz = 0.
- DIV (WORDS cycles, index WORDS-1 down to 0):
  - divisor q = k*D, 2*WORD_W bits.
  - Each cycle: dividend = {rem, term[i]} (3*WORD_W bits); term[i] = dividend / q (low WORD_W bits); rem = dividend % q.
  - rem is cleared at pass start; the final remainder is discarded (truncation).
  - nz ORs every new quotient word.
- ADD (WORDS cycles, index 0 up to WORDS-1): sum[i] = sum[i] + term[i] + carry; carry cleared at pass start, carry-out of the MSW discarded.
  - If nz == 0, ADD is skipped and the FSM goes straight to OUT.
  - iter_count increments at end of ADD.
  - Then: if k == MAX_K, set truncated and go to OUT; else k++, nz = 0, go to DIV.
- Latency per term: 2*WORDS cycles, plus 1 for INIT.
- OUT:
  - On entry: done pulses for 1 cycle and out_data is loaded.
  - Stream the WORDS words of sum, MSW first; out_word/out_valid are registered.
  - A word advances only on out_valid & out_ready. out_valid stays high and out_word stays stable while out_ready is low.
  - out_last accompanies word 0; after its handshake: busy = 0, out_valid = 0, FSM -> IDLE.
- start during busy (including the OUT stall) is ignored. start on the same cycle that returns to IDLE is also ignored.
- out_data holds its value until the next done.

Optional Feature:
- E_CALC_GUARD_EN defined:
  - term and sum arrays are WORDS+1 words; one guard word sits below LSW 0.
  - DIV and ADD passes take WORDS+1 cycles.
  - Outputs carry the upper WORDS words, truncated (no rounding).
- E_CALC_GUARD_EN undefined: arrays are exactly WORDS words; accumulated truncation error is at most iter_count LSBs low.

Decomposition:
- Package e_calc_pkg:
  - WORD_W default constant.
  - word_t typedef.
  - state enum (IDLE, INIT, DIV, ADD, OUT).
  - iter counter width constant.
- Sub-module e_calc_divstep: combinational {rem, word} / q step returning quotient word and new remainder; isolates the wide divider for later pipelining.

Test Plan:
- WORDS=4, D=1, start, out_ready=1:
  - stream is 0x0002, 0xB7E1, 0x5162, then word 0 in 0x8AE0..0x8AED.
  - done is 1 cycle; truncated=0; 16 <= iter_count <= 20.
- WORDS=4, D=2: word 3 = 0x0001, word 2 = 0xA612; D=0 gives results identical to D=1.
- out_ready toggled 1-0-0-1 during OUT: no word lost or duplicated; out_word stable while stalled; out_last only on the 4th handshake.
- MAX_K=3, D=1, WORDS=2: iter_count=3, truncated=1, sum = 2.6666 -> words 0x0002, 0xAAAA.
- start pulsed during DIV and during OUT stall: ignored, result unchanged; busy stays high.
- rst_n asserted mid-ADD: outputs 0 next edge, no done. A fresh start then gives the same result as the first test.
